// File: rtl/password_ctrl.sv
// Password-lock controller: collects 4 keypad digits, checks them on '#', and drives OPEN/FAIL/ALARM.
// Define PWD_CHANGE_EN to add the SET state, where the password can be changed from OPEN via 'A'.
module password_ctrl #(
  parameter logic [15:0] DEFAULT_PWD  = 16'h1234,
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned ERR_CYCLES   = 50000000,
  parameter int unsigned OPEN_CYCLES  = 250000000,
  parameter int unsigned ALARM_CYCLES = 500000000,
  parameter int unsigned TMR_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_num,
  output logic [15:0] entry,
  output logic [2:0]  entry_cnt,
  output logic        unlock,
  output logic        err,
  output logic        alarm,
  output logic [2:0]  fail_cnt,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_LOCKED = 3'd0,
    ST_OPEN   = 3'd1,
    ST_FAIL   = 3'd2,
`ifdef PWD_CHANGE_EN
    ST_ALARM  = 3'd3,
    ST_SET    = 3'd4
`else
    ST_ALARM  = 3'd3
`endif
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [TMR_W-1:0] ERR_LAST   = TMR_W'(ERR_CYCLES - 1);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] ALARM_LAST = TMR_W'(ALARM_CYCLES - 1);
  localparam logic [2:0]       FAIL_MAX   = 3'(MAX_FAIL);

  state_e             state_q, state_d;
  logic [15:0]        entry_q, entry_d;
  logic [2:0]         entry_cnt_q, entry_cnt_d;
  logic [2:0]         fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               unlock_q, unlock_d;
  logic               err_q, err_d;
  logic               alarm_q, alarm_d;
  logic [15:0]        pwd;

  logic               is_digit, is_star, is_hash;
  logic [2:0]         fail_inc;

`ifdef PWD_CHANGE_EN
  logic [15:0]        pwd_q, pwd_d;
  logic               is_a, is_b;
  assign pwd  = pwd_q;
  assign is_a = key_valid && (key_num == 4'hA);
  assign is_b = key_valid && (key_num == 4'hB);
`else
  assign pwd = DEFAULT_PWD;
`endif

  assign is_digit = key_valid && (key_num <= 4'd9);
  assign is_star  = key_valid && (key_num == KEY_STAR);
  assign is_hash  = key_valid && (key_num == KEY_HASH);
  assign fail_inc = fail_cnt_q + 3'd1;

  always_comb begin
    // NOTE: every next-value signal gets a default first, so no branch can infer a latch.
    state_d     = state_q;
    entry_d     = entry_q;
    entry_cnt_d = entry_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
`ifdef PWD_CHANGE_EN
    pwd_d       = pwd_q;
`endif

    case (state_q)
      ST_LOCKED: begin
        if (is_digit && entry_cnt_q < 3'd4) begin
          entry_d     = {entry_q[11:0], key_num};
          entry_cnt_d = entry_cnt_q + 3'd1;
        end else if (is_star) begin
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (is_hash) begin
          entry_d     = '0;
          entry_cnt_d = '0;
          if (entry_cnt_q == 3'd4 && entry_q == pwd) begin
            state_d    = ST_OPEN;
            fail_cnt_d = '0;
          end else begin
            fail_cnt_d = fail_inc;
            state_d    = (fail_inc == FAIL_MAX) ? ST_ALARM : ST_FAIL;
          end
        end
      end

      ST_FAIL: begin
        if (timer_q == ERR_LAST) state_d = ST_LOCKED;
        else                     timer_d = timer_q + 1'b1;
      end

      ST_OPEN: begin
        // Timer expiry is tested first so a key on the same cycle is dropped.
        if (timer_q == OPEN_LAST) begin
          state_d = ST_LOCKED;
        end else if (is_hash || is_star) begin
          state_d = ST_LOCKED;
`ifdef PWD_CHANGE_EN
        end else if (is_a) begin
          state_d     = ST_SET;
          entry_d     = '0;
          entry_cnt_d = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_ALARM: begin
        if (timer_q == ALARM_LAST) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

`ifdef PWD_CHANGE_EN
      ST_SET: begin
        if (is_digit && entry_cnt_q < 3'd4) begin
          entry_d     = {entry_q[11:0], key_num};
          entry_cnt_d = entry_cnt_q + 3'd1;
        end else if (is_star) begin
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (is_hash && entry_cnt_q == 3'd4) begin
          pwd_d       = entry_q;
          state_d     = ST_LOCKED;
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (is_b) begin
          state_d     = ST_LOCKED;
          entry_d     = '0;
          entry_cnt_d = '0;
        end
      end
`endif

      default: state_d = ST_LOCKED;
    endcase

    if (state_d != state_q) timer_d = '0;

    unlock_d = (state_d == ST_OPEN);
`ifdef PWD_CHANGE_EN
    if (state_d == ST_SET) unlock_d = 1'b1;
`endif
    err_d    = (state_d == ST_FAIL);
    alarm_d  = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOCKED;
      entry_q     <= '0;
      entry_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      err_q       <= 1'b0;
      alarm_q     <= 1'b0;
`ifdef PWD_CHANGE_EN
      // NOTE: pwd is a plain register, not a memory, so it can and must reload DEFAULT_PWD on reset.
      pwd_q       <= DEFAULT_PWD;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q     <= state_d;
      entry_q     <= entry_d;
      entry_cnt_q <= entry_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      err_q       <= err_d;
      alarm_q     <= alarm_d;
`ifdef PWD_CHANGE_EN
      pwd_q       <= pwd_d;
`endif
    end
  end

  assign entry     = entry_q;
  assign entry_cnt = entry_cnt_q;
  assign unlock    = unlock_q;
  assign err       = err_q;
  assign alarm     = alarm_q;
  assign fail_cnt  = fail_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_password_ctrl.sv
// Scoreboard bench for password_ctrl with short timer parameters; covers the PWD_CHANGE_EN path when defined.
module tb_password_ctrl;

  localparam logic [2:0] S_LOCK  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_FAIL  = 3'd2;
  localparam logic [2:0] S_ALARM = 3'd3;
  localparam logic [2:0] S_SET   = 3'd4;

  typedef struct packed {
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        unlock;
    logic        err;
    logic        alarm;
    logic [2:0]  fail;
    logic [2:0]  st;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_num;
  logic [15:0] entry;
  logic [2:0]  entry_cnt;
  logic        unlock;
  logic        err;
  logic        alarm;
  logic [2:0]  fail_cnt;
  logic [2:0]  state_o;

  int   n_total = 0;
  int   n_bad   = 0;
  obs_t sb[$];

  password_ctrl #(
    .DEFAULT_PWD (16'h1234),
    .MAX_FAIL    (3),
    .ERR_CYCLES  (4),
    .OPEN_CYCLES (6),
    .ALARM_CYCLES(8),
    .TMR_W       (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_num  (key_num),
    .entry    (entry),
    .entry_cnt(entry_cnt),
    .unlock   (unlock),
    .err      (err),
    .alarm    (alarm),
    .fail_cnt (fail_cnt),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [15:0] e, input logic [2:0] c,
                              input logic [2:0] s, input logic [2:0] f);
    obs_t o;
    o.entry  = e;
    o.cnt    = c;
    o.st     = s;
    o.fail   = f;
    o.unlock = (s == S_OPEN) || (s == S_SET);
    o.err    = (s == S_FAIL);
    o.alarm  = (s == S_ALARM);
    return o;
  endfunction

  task automatic compare(input string lbl);
    obs_t e;
    e = sb.pop_front();
    check({lbl, ".entry"},  32'(entry),     32'(e.entry));
    check({lbl, ".cnt"},    32'(entry_cnt), 32'(e.cnt));
    check({lbl, ".unlock"}, 32'(unlock),    32'(e.unlock));
    check({lbl, ".err"},    32'(err),       32'(e.err));
    check({lbl, ".alarm"},  32'(alarm),     32'(e.alarm));
    check({lbl, ".fail"},   32'(fail_cnt),  32'(e.fail));
    check({lbl, ".state"},  32'(state_o),   32'(e.st));
  endtask

  // Called at a falling edge: drive one cycle of input, then compare at the next falling edge.
  task automatic step(input string lbl, input logic v, input logic [3:0] k, input obs_t exp);
    key_valid = v;
    key_num   = v ? k : 4'h0;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_num   = 4'h0;
    @(negedge clk);
    compare(lbl);
  endtask

  task automatic press(input string lbl, input logic [3:0] k, input obs_t exp);
    step(lbl, 1'b1, k, exp);
  endtask

  task automatic idle(input string lbl, input obs_t exp);
    step(lbl, 1'b0, 4'h0, exp);
  endtask

  task automatic observe_now(input string lbl, input obs_t exp);
    sb.push_back(exp);
    compare(lbl);
  endtask

  // Enters 1,2,3,4,# from LOCKED with the given fail count; ends in OPEN.
  task automatic unlock_default(input string lbl, input logic [2:0] f);
    press({lbl, ".d1"}, 4'h1, mk(16'h0001, 3'd1, S_LOCK, f));
    press({lbl, ".d2"}, 4'h2, mk(16'h0012, 3'd2, S_LOCK, f));
    press({lbl, ".d3"}, 4'h3, mk(16'h0123, 3'd3, S_LOCK, f));
    press({lbl, ".d4"}, 4'h4, mk(16'h1234, 3'd4, S_LOCK, f));
    press({lbl, ".hash"}, 4'hF, mk(16'h0000, 3'd0, S_OPEN, 3'd0));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_num   = 4'h0;
    @(negedge clk);
    @(negedge clk);
    observe_now("reset", mk(16'h0, 3'd0, S_LOCK, 3'd0));
    rst_n = 1'b1;

    // Entry buffer: fifth digit and letters ignored, '*' clears.
    press("t4.d1", 4'h1, mk(16'h0001, 3'd1, S_LOCK, 3'd0));
    press("t4.d2", 4'h2, mk(16'h0012, 3'd2, S_LOCK, 3'd0));
    press("t4.d3", 4'h3, mk(16'h0123, 3'd3, S_LOCK, 3'd0));
    press("t4.d4", 4'h4, mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    press("t4.d5", 4'h5, mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    press("t4.d7", 4'h7, mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    press("t4.kA", 4'hA, mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    idle("t4.idle", mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    press("t4.star", 4'hE, mk(16'h0000, 3'd0, S_LOCK, 3'd0));

    // Correct code opens for exactly 6 cycles; digits in OPEN are ignored.
    unlock_default("t1", 3'd0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) press("t5.open_digit", 4'h7, mk(16'h0, 3'd0, S_OPEN, 3'd0));
      else        idle("t5.open_hold", mk(16'h0, 3'd0, S_OPEN, 3'd0));
    end
    idle("t5.relock_timeout", mk(16'h0, 3'd0, S_LOCK, 3'd0));

    // '#' and '*' relock immediately without counting a failure.
    unlock_default("t5h", 3'd0);
    press("t5.relock_hash", 4'hF, mk(16'h0, 3'd0, S_LOCK, 3'd0));
    unlock_default("t5s", 3'd0);
    press("t5.relock_star", 4'hE, mk(16'h0, 3'd0, S_LOCK, 3'd0));

    // Wrong code: FAIL for exactly 4 cycles, keys ignored.
    press("t2.d1", 4'h1, mk(16'h0001, 3'd1, S_LOCK, 3'd0));
    press("t2.d2", 4'h2, mk(16'h0012, 3'd2, S_LOCK, 3'd0));
    press("t2.d3", 4'h3, mk(16'h0123, 3'd3, S_LOCK, 3'd0));
    press("t2.d5", 4'h5, mk(16'h1235, 3'd4, S_LOCK, 3'd0));
    press("t2.hash", 4'hF, mk(16'h0, 3'd0, S_FAIL, 3'd1));
    for (int i = 1; i <= 3; i++) begin
      if (i == 1) press("t2.fail_key", 4'h1, mk(16'h0, 3'd0, S_FAIL, 3'd1));
      else        idle("t2.fail_hold", mk(16'h0, 3'd0, S_FAIL, 3'd1));
    end
    idle("t2.fail_exit", mk(16'h0, 3'd0, S_LOCK, 3'd1));
    press("t2.d9", 4'h9, mk(16'h0009, 3'd1, S_LOCK, 3'd1));
    press("t2.short_hash", 4'hF, mk(16'h0, 3'd0, S_FAIL, 3'd2));
    for (int i = 1; i <= 3; i++) idle("t2.fail2_hold", mk(16'h0, 3'd0, S_FAIL, 3'd2));
    press("t2.key_at_expiry", 4'h1, mk(16'h0, 3'd0, S_LOCK, 3'd2));

    // Third consecutive failure: ALARM for exactly 8 cycles, then fail count clears.
    press("t3.hash", 4'hF, mk(16'h0, 3'd0, S_ALARM, 3'd3));
    for (int i = 1; i <= 7; i++) press("t3.alarm_hold", 4'(i), mk(16'h0, 3'd0, S_ALARM, 3'd3));
    idle("t3.alarm_exit", mk(16'h0, 3'd0, S_LOCK, 3'd0));

    // A success clears an outstanding failure count.
    press("fc.hash", 4'hF, mk(16'h0, 3'd0, S_FAIL, 3'd1));
    for (int i = 1; i <= 3; i++) idle("fc.fail_hold", mk(16'h0, 3'd0, S_FAIL, 3'd1));
    idle("fc.fail_exit", mk(16'h0, 3'd0, S_LOCK, 3'd1));
    unlock_default("fc", 3'd1);
    press("fc.relock", 4'hF, mk(16'h0, 3'd0, S_LOCK, 3'd0));

`ifdef PWD_CHANGE_EN
    // Change password to 5678 via SET; SET has no timeout.
    unlock_default("t6", 3'd0);
    press("t6.enter_set", 4'hA, mk(16'h0, 3'd0, S_SET, 3'd0));
    for (int i = 1; i <= 8; i++) idle("t6.set_hold", mk(16'h0, 3'd0, S_SET, 3'd0));
    press("t6.s5", 4'h5, mk(16'h0005, 3'd1, S_SET, 3'd0));
    press("t6.s6", 4'h6, mk(16'h0056, 3'd2, S_SET, 3'd0));
    press("t6.short_hash", 4'hF, mk(16'h0056, 3'd2, S_SET, 3'd0));
    press("t6.s7", 4'h7, mk(16'h0567, 3'd3, S_SET, 3'd0));
    press("t6.s8", 4'h8, mk(16'h5678, 3'd4, S_SET, 3'd0));
    press("t6.commit", 4'hF, mk(16'h0, 3'd0, S_LOCK, 3'd0));
    press("t6.o1", 4'h1, mk(16'h0001, 3'd1, S_LOCK, 3'd0));
    press("t6.o2", 4'h2, mk(16'h0012, 3'd2, S_LOCK, 3'd0));
    press("t6.o3", 4'h3, mk(16'h0123, 3'd3, S_LOCK, 3'd0));
    press("t6.o4", 4'h4, mk(16'h1234, 3'd4, S_LOCK, 3'd0));
    press("t6.old_rejected", 4'hF, mk(16'h0, 3'd0, S_FAIL, 3'd1));
    for (int i = 1; i <= 3; i++) idle("t6.fail_hold", mk(16'h0, 3'd0, S_FAIL, 3'd1));
    idle("t6.fail_exit", mk(16'h0, 3'd0, S_LOCK, 3'd1));
    press("t6.n5", 4'h5, mk(16'h0005, 3'd1, S_LOCK, 3'd1));
    press("t6.n6", 4'h6, mk(16'h0056, 3'd2, S_LOCK, 3'd1));
    press("t6.n7", 4'h7, mk(16'h0567, 3'd3, S_LOCK, 3'd1));
    press("t6.n8", 4'h8, mk(16'h5678, 3'd4, S_LOCK, 3'd1));
    press("t6.new_accepted", 4'hF, mk(16'h0, 3'd0, S_OPEN, 3'd0));
    // 'B' aborts SET without touching the password.
    press("t6.enter_set2", 4'hA, mk(16'h0, 3'd0, S_SET, 3'd0));
    press("t6.s9", 4'h9, mk(16'h0009, 3'd1, S_SET, 3'd0));
    press("t6.abort", 4'hB, mk(16'h0, 3'd0, S_LOCK, 3'd0));
    press("t6.m5", 4'h5, mk(16'h0005, 3'd1, S_LOCK, 3'd0));
    press("t6.m6", 4'h6, mk(16'h0056, 3'd2, S_LOCK, 3'd0));
    press("t6.m7", 4'h7, mk(16'h0567, 3'd3, S_LOCK, 3'd0));
    press("t6.m8", 4'h8, mk(16'h5678, 3'd4, S_LOCK, 3'd0));
    press("t6.still_5678", 4'hF, mk(16'h0, 3'd0, S_OPEN, 3'd0));
`else
    // Without the SET feature, 'A' in OPEN is ignored.
    unlock_default("na", 3'd0);
    press("na.key_a", 4'hA, mk(16'h0, 3'd0, S_OPEN, 3'd0));
    idle("na.still_open", mk(16'h0, 3'd0, S_OPEN, 3'd0));
`endif

    // Asynchronous reset in OPEN, away from any clock edge; password reverts to default.
    #2;
    rst_n = 1'b0;
    #1;
    observe_now("rst.mid_op", mk(16'h0, 3'd0, S_LOCK, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    unlock_default("rst", 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
